apb_req_arbiter: RTL

//  Shares one apb_master TAP-side command port between NUM_REQ requesters.

---
 rtl/apb_req_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter
//   Round-robin front end that shares one apb_master command port between
//   NUM_REQ requesters. A winner's RW/ADDR/WDATA are latched, issued as a
//   single-cycle TRANSFER pulse and held until the master's DONE. RDATA/FAIL
//   then go back to the winner together with a one-cycle done strobe.
//   Completions with a non-zero FAIL are counted in a saturating counter.
// Ports
//   PCLK, PRESETn              clock, async active-low reset
//   req_i/rw_i                 per-requester request level and direction
//   addr_i/wdata_i             flattened payload, requester k at [k*W +: W]
//   gnt_o/done_o               one-hot owner / one-hot completion strobe
//   rdata_o/fail_o             result of the last completed transfer
//   busy_o                     arbiter not idle
//   err_cnt_o                  saturating count of failed completions
//   TRANSFER_o/RW_o/ADDR_o/WDATA_o   command to apb_master
//   DONE_i/FAIL_i/RDATA_i      response from apb_master
module apb_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ERR_WIDTH  = 2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0]             rw_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             done_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic [ERR_WIDTH-1:0]           fail_o,
  output logic                           busy_o,
  output logic [CNT_WIDTH-1:0]           err_cnt_o,
  output logic                           TRANSFER_o,
  output logic                           RW_o,
  output logic [ADDR_WIDTH-1:0]          ADDR_o,
  output logic [DATA_WIDTH-1:0]          WDATA_o,
  input  logic                           DONE_i,
  input  logic [ERR_WIDTH-1:0]           FAIL_i,
  input  logic [DATA_WIDTH-1:0]          RDATA_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                               state;
  logic [IDX_W-1:0]                     last_q;
  logic [IDX_W-1:0]                     win;
  logic [IDX_W-1:0]                     cand;
  logic                                 found;
  logic [NUM_REQ-1:0]                   win_oh;
  // packed views share the flattened layout: element k sits at [k*W +: W]
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   addr_v;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   wdata_v;

  assign addr_v  = addr_i;
  assign wdata_v = wdata_i;

  // Search last+1, last+2, ... so the previous owner is considered last.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state      <= IDLE;
      last_q     <= IDX_W'(NUM_REQ - 1);
      gnt_o      <= '0;
      done_o     <= '0;
      rdata_o    <= '0;
      fail_o     <= '0;
      busy_o     <= 1'b0;
      err_cnt_o  <= '0;
      TRANSFER_o <= 1'b0;
      RW_o       <= 1'b0;
      ADDR_o     <= '0;
      WDATA_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            RW_o       <= rw_i[win];
            ADDR_o     <= addr_v[win];
            WDATA_o    <= wdata_v[win];
            gnt_o      <= win_oh;
            last_q     <= win;
            TRANSFER_o <= 1'b1;
            busy_o     <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          TRANSFER_o <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          // DONE_i only matters here; strays in other states are dropped
          if (DONE_i) begin
            rdata_o <= RDATA_i;
            fail_o  <= FAIL_i;
            if ((|FAIL_i) && !(&err_cnt_o))
              err_cnt_o <= err_cnt_o + CNT_WIDTH'(1);
            done_o  <= gnt_o;
            state   <= RESP;
          end
        end
        RESP: begin
          done_o <= '0;
          gnt_o  <= '0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
